// File: rtl/unary_multiplier_stream_if.sv
// Handshake bundle for unary_multiplier_stream: frame control, two serial
// operand streams with valid/ready, and a backpressured result stream.
interface unary_multiplier_stream_if;
    logic start;
    logic mode;
    logic a;
    logic a_valid;
    logic a_ready;
    logic b;
    logic b_valid;
    logic b_ready;
    logic y;
    logic y_valid;
    logic y_ready;
    logic busy;
    logic done;

    modport master (
        output start, mode, a, a_valid, b, b_valid, y_ready,
        input  a_ready, b_ready, y, y_valid, busy, done
    );

    modport slave (
        input  start, mode, a, a_valid, b, b_valid, y_ready,
        output a_ready, b_ready, y, y_valid, busy, done
    );
endinterface

// File: rtl/unary_multiplier_stream.sv
// Streaming unary-bitstream multiplier / scaled adder. Result bits are
// emitted as soon as interval bounds on the partially received operands
// prove that the bit cannot spoil the final ones count (or, with EPSILON>0,
// once the bounds are narrow enough to speculate).
module unary_multiplier_stream #(
    parameter int STREAM_LEN = 32,
    parameter int EPSILON    = 0,
    parameter int CW         = $clog2(STREAM_LEN + 1)
) (
    input logic clk,
    input logic reset,
    unary_multiplier_stream_if.slave bus
);
    localparam int SH = $clog2(STREAM_LEN);
    localparam logic [CW-1:0] LEN = CW'(STREAM_LEN);
    localparam logic [CW-1:0] EPS = CW'(EPSILON);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Product bound in result ones: floor(x*z / L).
    function automatic logic [CW-1:0] mul_bound(input logic [CW-1:0] x, input logic [CW-1:0] z);
        logic [2*CW-1:0] p;
        p = {{CW{1'b0}}, x} * {{CW{1'b0}}, z};
        return CW'(p >> SH);
    endfunction

    // Scaled-sum bound in result ones: floor((x+z) / 2).
    function automatic logic [CW-1:0] add_bound(input logic [CW-1:0] x, input logic [CW-1:0] z);
        logic [CW:0] s;
        s = {1'b0, x} + {1'b0, z};
        return CW'(s >> 1);
    endfunction

    logic [1:0]    state;
    logic          mode_q;
    logic [CW-1:0] a_cnt, a_ones, b_cnt, b_ones;
    logic [CW-1:0] y_cnt, y_ones;
    logic          y_p0, vld_p0;

    logic [CW-1:0] a_hi, b_hi, lo, hi, rem;
    logic          a_fire, b_fire, y_fire, slot_free;
    logic          one_ok, zero_ok, spec_ok, mid_one, emit, emit_bit;

    assign bus.a_ready = (state == RUN) && (a_cnt < LEN);
    assign bus.b_ready = (state == RUN) && (b_cnt < LEN);
    assign bus.y       = y_p0;
    assign bus.y_valid = vld_p0;
    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);

    assign a_fire = bus.a_valid && bus.a_ready;
    assign b_fire = bus.b_valid && bus.b_ready;
    assign y_fire = vld_p0 && bus.y_ready;

    // Unreceived operand bits count as ones for the upper bound.
    assign a_hi = a_ones + LEN - a_cnt;
    assign b_hi = b_ones + LEN - b_cnt;
    assign lo   = mode_q ? add_bound(a_ones, b_ones) : mul_bound(a_ones, b_ones);
    assign hi   = mode_q ? add_bound(a_hi, b_hi)     : mul_bound(a_hi, b_hi);
    assign rem  = LEN - y_cnt;

    // A 1 is safe while fewer than lo ones are out; a 0 is safe while the
    // remaining slots can still reach any total up to hi.
    assign one_ok    = y_ones < lo;
    assign zero_ok   = ({1'b0, y_ones} + {1'b0, rem}) > {1'b0, hi};
    assign mid_one   = ({y_ones, 1'b0} + {1'b0, rem}) < ({1'b0, lo} + {1'b0, hi});
    assign spec_ok   = (hi >= lo) && ((hi - lo) <= EPS);
    assign slot_free = !vld_p0 || bus.y_ready;
    assign emit      = (state == RUN) && slot_free && (rem != '0) && (one_ok || zero_ok || spec_ok);
    assign emit_bit  = (one_ok && !zero_ok) || ((one_ok == zero_ok) && mid_one);

    // Frame sequencing: IDLE -> RUN on start, RUN -> DONE after the last result handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            mode_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        mode_q <= bus.mode;
                    end
                end
                RUN: begin
                    if (y_fire && (y_cnt == LEN)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operand counters: bits received and ones received per stream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_cnt  <= '0;
            a_ones <= '0;
            b_cnt  <= '0;
            b_ones <= '0;
        end else if ((state == IDLE) && bus.start) begin
            a_cnt  <= '0;
            a_ones <= '0;
            b_cnt  <= '0;
            b_ones <= '0;
        end else begin
            if (a_fire) begin
                a_cnt  <= a_cnt + 1'b1;
                a_ones <= a_ones + CW'(bus.a);
            end
            if (b_fire) begin
                b_cnt  <= b_cnt + 1'b1;
                b_ones <= b_ones + CW'(bus.b);
            end
        end
    end

    // Result stage: load a decided bit into the output register, hold it under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_cnt  <= '0;
            y_ones <= '0;
            y_p0   <= 1'b0;
            vld_p0 <= 1'b0;
        end else if ((state == IDLE) && bus.start) begin
            y_cnt  <= '0;
            y_ones <= '0;
            y_p0   <= 1'b0;
            vld_p0 <= 1'b0;
        end else if (emit) begin
            y_p0   <= emit_bit;
            vld_p0 <= 1'b1;
            y_cnt  <= y_cnt + 1'b1;
            y_ones <= y_ones + CW'(emit_bit);
        end else if (y_fire) begin
            vld_p0 <= 1'b0;
            if (y_cnt == LEN) y_p0 <= 1'b0;
        end
    end
endmodule

// File: tb/tb_unary_multiplier_stream.sv
// Directed bench for unary_multiplier_stream at STREAM_LEN=16, with one
// exact (EPSILON=0) and one speculative (EPSILON=2) instance behind a mux.
module tb_unary_multiplier_stream;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic start, mode, a, a_valid, b, b_valid, y_ready, sel;
    logic a_ready, b_ready, y, y_valid, busy, done;

    int errors = 0;
    int checks = 0;

    unary_multiplier_stream_if if0 ();
    unary_multiplier_stream_if if2 ();

    assign if0.start   = start & ~sel;
    assign if0.mode    = mode;
    assign if0.a       = a;
    assign if0.a_valid = a_valid & ~sel;
    assign if0.b       = b;
    assign if0.b_valid = b_valid & ~sel;
    assign if0.y_ready = y_ready;
    assign if2.start   = start & sel;
    assign if2.mode    = mode;
    assign if2.a       = a;
    assign if2.a_valid = a_valid & sel;
    assign if2.b       = b;
    assign if2.b_valid = b_valid & sel;
    assign if2.y_ready = y_ready;

    assign a_ready = sel ? if2.a_ready : if0.a_ready;
    assign b_ready = sel ? if2.b_ready : if0.b_ready;
    assign y       = sel ? if2.y       : if0.y;
    assign y_valid = sel ? if2.y_valid : if0.y_valid;
    assign busy    = sel ? if2.busy    : if0.busy;
    assign done    = sel ? if2.done    : if0.done;

    unary_multiplier_stream #(.STREAM_LEN(16), .EPSILON(0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0)
    );
    unary_multiplier_stream #(.STREAM_LEN(16), .EPSILON(2)) dut2 (
        .clk(clk), .reset(reset), .bus(if2)
    );

    function automatic logic [15:0] mk_bits(input int k, input int rot);
        logic [31:0] m;
        logic [15:0] v;
        m = (k >= 16) ? 32'h0000_FFFF : ((32'd1 << k) - 32'd1);
        v = m[15:0];
        return (v << rot) | (v >> (16 - rot));
    endfunction

    // Drives one frame and collects the result stream.
    task automatic run_frame(input logic [15:0] abits, input logic [15:0] bbits, input logic md,
                             input bit rand_v, input bit bp, input bit use_b, input int flip_at,
                             input bit start_in_done,
                             output int ones, output int nbits, output int first_y_acc,
                             output bit got_done);
        int ai, bi;
        logic prev_stall, prev_y;
        ones = 0; nbits = 0; ai = 0; bi = 0; first_y_acc = -1; got_done = 1'b0;
        prev_stall = 1'b0; prev_y = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = md; a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 600 && !got_done; cyc++) begin
            if (cyc == 0) begin
                checks++;
                if ({busy, a_ready, b_ready} !== 3'b111) begin
                    errors++;
                    $display("FAIL start_ready: busy/a_ready/b_ready=%b expected 111", {busy, a_ready, b_ready});
                end
            end
            if (cyc == flip_at) mode = ~mode;
            a_valid = (ai < 16) && (!rand_v || ($urandom_range(0, 1) == 1));
            a = 1'b0;
            if (ai < 16) a = abits[ai];
            b_valid = use_b && (bi < 16) && (!rand_v || ($urandom_range(0, 1) == 1));
            b = 1'b0;
            if (bi < 16) b = bbits[bi];
            y_ready = !bp || ($urandom_range(0, 1) == 1);
            if (prev_stall) begin
                checks++;
                if (y_valid !== 1'b1 || y !== prev_y) begin
                    errors++;
                    $display("FAIL stall_hold: y_valid=%b y=%b expected 1 and %b", y_valid, y, prev_y);
                end
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                if (start_in_done) start = 1'b1;
            end
            if (y_valid === 1'b1 && first_y_acc < 0) first_y_acc = ai;
            if (a_valid && a_ready) ai++;
            if (b_valid && b_ready) bi++;
            if (y_valid && y_ready) begin
                ones += int'(y);
                nbits++;
            end
            prev_stall = y_valid && !y_ready;
            prev_y = y;
            @(negedge clk);
        end
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL after_done: done/busy=%b expected 00", {done, busy});
        end
        start = 1'b0; a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mode = 1'b0; a = 1'b0; a_valid = 1'b0;
        b = 1'b0; b_valid = 1'b0; y_ready = 1'b1; sel = 1'b0;
        #1;
        checks++;
        if ({a_ready, b_ready, y, y_valid, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000", {a_ready, b_ready, y, y_valid, busy, done});
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, y_valid} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: busy/done/y_valid=%b expected 000", {busy, done, y_valid});
        end
    endtask

    task automatic test_mult_basic();
        int ones, nbits, fy;
        bit gd;
        run_frame(mk_bits(12, 0), mk_bits(8, 4), 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, ones, nbits, fy, gd);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: busy=%b expected 0", busy);
        end
        start = 1'b0;
        checks++;
        if (ones !== 6) begin errors++; $display("FAIL mult_12x8_ones: got %0d expected 6", ones); end
        checks++;
        if (nbits !== 16) begin errors++; $display("FAIL mult_12x8_bits: got %0d expected 16", nbits); end
        checks++;
        if (gd !== 1'b1) begin errors++; $display("FAIL mult_12x8_done: got %0d expected 1", gd); end
    endtask

    task automatic test_b_stall();
        int ones, nbits, fy;
        bit gd;
        run_frame(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, ones, nbits, fy, gd);
        checks++;
        if (fy !== 2) begin errors++; $display("FAIL b_stall_first_y: A accepted=%0d expected 2", fy); end
        checks++;
        if (ones !== 0 || nbits !== 16) begin
            errors++;
            $display("FAIL b_stall_zeros: ones=%0d bits=%0d expected 0 and 16", ones, nbits);
        end
        checks++;
        if (gd !== 1'b1) begin errors++; $display("FAIL b_stall_done: got %0d expected 1", gd); end
    endtask

    task automatic test_add_mode_flip();
        int ones, nbits, fy;
        bit gd;
        run_frame(mk_bits(12, 3), mk_bits(4, 9), 1'b1, 1'b0, 1'b0, 1'b1, 5, 1'b0, ones, nbits, fy, gd);
        checks++;
        if (ones !== 8 || nbits !== 16) begin
            errors++;
            $display("FAIL add_12_4: ones=%0d bits=%0d expected 8 and 16", ones, nbits);
        end
        checks++;
        if (gd !== 1'b1) begin errors++; $display("FAIL add_12_4_done: got %0d expected 1", gd); end
    endtask

    task automatic test_backpressure();
        int ones, nbits, fy;
        bit gd;
        run_frame(mk_bits(12, 0), mk_bits(8, 0), 1'b0, 1'b1, 1'b1, 1'b1, -1, 1'b0, ones, nbits, fy, gd);
        checks++;
        if (ones !== 6 || nbits !== 16 || gd !== 1'b1) begin
            errors++;
            $display("FAIL bp_mult: ones=%0d bits=%0d done=%0d expected 6 16 1", ones, nbits, gd);
        end
        run_frame(mk_bits(11, 2), mk_bits(5, 7), 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b0, ones, nbits, fy, gd);
        checks++;
        if (ones !== 8 || nbits !== 16 || gd !== 1'b1) begin
            errors++;
            $display("FAIL bp_add: ones=%0d bits=%0d done=%0d expected 8 16 1", ones, nbits, gd);
        end
    endtask

    task automatic test_eps2_random();
        int ones, nbits, fy, ka, kb, p, d;
        bit gd;
        logic [15:0] ab, bb;
        logic md;
        sel = 1'b1;
        for (int f = 0; f < 200; f++) begin
            ab = 16'($urandom);
            bb = 16'($urandom);
            md = 1'($urandom_range(0, 1));
            ka = $countones(ab);
            kb = $countones(bb);
            p = md ? (ka + kb) / 2 : (ka * kb) / 16;
            run_frame(ab, bb, md, 1'b1, 1'b1, 1'b1, -1, 1'b0, ones, nbits, fy, gd);
            d = ones - p;
            checks++;
            if (d > 2 || d < -2 || nbits !== 16 || gd !== 1'b1) begin
                errors++;
                $display("FAIL eps2 f=%0d mode=%0d a=%0d b=%0d: ones=%0d bits=%0d done=%0d expected %0d+-2 16 1",
                         f, md, ka, kb, ones, nbits, gd, p);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_sweep_exact();
        int ones, nbits, fy, p;
        bit gd;
        for (int md = 0; md < 2; md++) begin
            for (int ka = 0; ka <= 16; ka++) begin
                for (int kb = 0; kb <= 16; kb++) begin
                    p = (md == 1) ? (ka + kb) / 2 : (ka * kb) / 16;
                    run_frame(mk_bits(ka, (ka * 5) % 16), mk_bits(kb, (kb * 3) % 16), 1'(md),
                              1'b0, 1'b0, 1'b1, -1, 1'b0, ones, nbits, fy, gd);
                    checks++;
                    if (ones !== p || nbits !== 16 || gd !== 1'b1) begin
                        errors++;
                        $display("FAIL sweep mode=%0d a=%0d b=%0d: ones=%0d bits=%0d done=%0d expected %0d 16 1",
                                 md, ka, kb, ones, nbits, gd, p);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int ones, nbits, fy;
        bit gd, seen, saw_done;
        seen = 1'b0;
        saw_done = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; y_ready = 1'b0;
        a = 1'b1; b = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (y_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL mid_y_valid: got %0d expected 1", seen); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({a_ready, b_ready, y, y_valid, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: got %b expected 000000", {a_ready, b_ready, y, y_valid, busy, done});
        end
        a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL reset_no_done: got %0d expected 0", saw_done); end
        run_frame(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, ones, nbits, fy, gd);
        checks++;
        if (ones !== 16 || nbits !== 16 || gd !== 1'b1) begin
            errors++;
            $display("FAIL full_after_reset: ones=%0d bits=%0d done=%0d expected 16 16 1", ones, nbits, gd);
        end
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_b_stall();
        test_add_mode_flip();
        test_backpressure();
        test_eps2_random();
        test_sweep_exact();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
